// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// controller FSM states and the hard-wired zero register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } ctrl_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding select for one EX-stage source operand; the younger MEM result
// wins over WB, and x0 is never forwarded.
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_ex,
  input  logic [4:0] rd_mem,
  input  logic       reg_wr_en_mem,
  input  logic [4:0] rd_wb,
  input  logic       reg_wr_en_wb,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_wr_en_mem && (rd_mem != REG_X0) && (rd_mem == rs_ex))
      fwd_sel = FWD_MEM;
    else if (reg_wr_en_wb && (rd_wb != REG_X0) && (rd_wb == rs_ex))
      fwd_sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/forwarding controller for the 5-stage core, including the
// DMEM wait FSM with timeout and a saturating frozen-cycle counter.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1_ID,
  input  logic [4:0]      rs2_ID,
  input  logic [4:0]      rs1_EX,
  input  logic [4:0]      rs2_EX,
  input  logic [4:0]      rd_EX,
  input  logic            reg_wr_en_EX,
  input  logic            is_load_EX,
  input  logic [4:0]      rd_MEM,
  input  logic [4:0]      rd_WB,
  input  logic            reg_wr_en_MEM,
  input  logic            reg_wr_en_WB,
  input  logic            mispredict_EX,
  input  logic            mem_req_MEM,
  input  logic            dmem_ready,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic            stall_IF,
  output logic            stall_ID,
  output logic            stall_EX,
  output logic            stall_MEM,
  output logic            flush_ID,
  output logic            flush_EX,
  output logic            flush_WB,
  output logic            dmem_timeout,
  output logic [XLEN-1:0] stall_cnt
);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_set;
  logic             freeze;
  logic             load_use;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  hazard_fwd_unit u_fwd_a (
    .rs_ex         (rs1_EX),
    .rd_mem        (rd_MEM),
    .reg_wr_en_mem (reg_wr_en_MEM),
    .rd_wb         (rd_WB),
    .reg_wr_en_wb  (reg_wr_en_WB),
    .fwd_sel       (fwd_a_raw)
  );

  hazard_fwd_unit u_fwd_b (
    .rs_ex         (rs2_EX),
    .rd_mem        (rd_MEM),
    .reg_wr_en_mem (reg_wr_en_MEM),
    .rd_wb         (rd_WB),
    .reg_wr_en_wb  (reg_wr_en_WB),
    .fwd_sel       (fwd_b_raw)
  );

  assign fwd_a_sel = reset ? FWD_RF : fwd_a_raw;
  assign fwd_b_sel = reset ? FWD_RF : fwd_b_raw;

  assign load_use = is_load_EX && reg_wr_en_EX && (rd_EX != REG_X0) &&
                    ((rd_EX == rs1_ID) || (rd_EX == rs2_ID));

  // A request dropped mid-wait counts as not-ready rather than completing.
  always_comb begin
    freeze = 1'b0;
    case (state_q)
      RUN:      freeze = mem_req_MEM && !dmem_ready;
      MEM_WAIT: freeze = !(mem_req_MEM && dmem_ready);
      ERR:      freeze = 1'b1;
      default:  freeze = 1'b0;
    endcase
  end

  always_comb begin
    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    stall_EX  = 1'b0;
    stall_MEM = 1'b0;
    flush_ID  = 1'b0;
    flush_EX  = 1'b0;
    flush_WB  = 1'b0;
    if (!reset) begin
      if (freeze) begin
        stall_IF  = 1'b1;
        stall_ID  = 1'b1;
        stall_EX  = 1'b1;
        stall_MEM = 1'b1;
        flush_WB  = 1'b1;
      end else if (mispredict_EX) begin
        flush_ID = 1'b1;
        flush_EX = 1'b1;
      end else if (load_use) begin
        stall_IF = 1'b1;
        stall_ID = 1'b1;
        flush_EX = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_set = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req_MEM && !dmem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_req_MEM && dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT)) begin
          state_d     = ERR;
          timeout_set = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      wait_cnt_q   <= '0;
      dmem_timeout <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (timeout_set)
        dmem_timeout <= 1'b1;
      if (freeze && (stall_cnt != '1))
        stall_cnt <= stall_cnt + XLEN'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, multi-cycle
// DMEM sequences and a randomized run against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] FRZ  = 7'b1111001;
  localparam logic [6:0] MSP  = 7'b0000110;
  localparam logic [6:0] LU   = 7'b1100010;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [4:0]      rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
  logic            reg_wr_en_EX, is_load_EX, reg_wr_en_MEM, reg_wr_en_WB;
  logic            mispredict_EX, mem_req_MEM, dmem_ready;
  logic [1:0]      fwd_a_sel, fwd_b_sel;
  logic            stall_IF, stall_ID, stall_EX, stall_MEM;
  logic            flush_ID, flush_EX, flush_WB;
  logic            dmem_timeout;
  logic [XLEN-1:0] stall_cnt;
  logic [6:0]      ctl_obs;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0] rs1_ID, rs2_ID, rd_EX;
    logic       is_load_EX, reg_wr_en_EX;
    logic [4:0] rs1_EX, rs2_EX, rd_MEM;
    logic       reg_wr_en_MEM;
    logic [4:0] rd_WB;
    logic       reg_wr_en_WB, mispredict_EX, mem_req_MEM, dmem_ready;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [1:0] fa, fb;
    logic [6:0] ctl;
  } vec_t;

  pipeline_hazard_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
    .rd_EX(rd_EX), .reg_wr_en_EX(reg_wr_en_EX), .is_load_EX(is_load_EX),
    .rd_MEM(rd_MEM), .rd_WB(rd_WB),
    .reg_wr_en_MEM(reg_wr_en_MEM), .reg_wr_en_WB(reg_wr_en_WB),
    .mispredict_EX(mispredict_EX), .mem_req_MEM(mem_req_MEM), .dmem_ready(dmem_ready),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX), .stall_MEM(stall_MEM),
    .flush_ID(flush_ID), .flush_EX(flush_EX), .flush_WB(flush_WB),
    .dmem_timeout(dmem_timeout), .stall_cnt(stall_cnt)
  );

  assign ctl_obs = {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, flush_WB};

  always #5 clk = ~clk;

  function automatic vec_t fv(input logic [4:0] r1id, r2id, rdex, input logic ld, wrex,
                              input logic [4:0] r1ex, r2ex, rdm, input logic wrm,
                              input logic [4:0] rdw, input logic wrw, misp,
                              input logic [1:0] fa, fb, input logic [6:0] ctl);
    vec_t v;
    v = '0;
    v.in.rs1_ID = r1id; v.in.rs2_ID = r2id; v.in.rd_EX = rdex;
    v.in.is_load_EX = ld; v.in.reg_wr_en_EX = wrex;
    v.in.rs1_EX = r1ex; v.in.rs2_EX = r2ex;
    v.in.rd_MEM = rdm; v.in.reg_wr_en_MEM = wrm;
    v.in.rd_WB = rdw; v.in.reg_wr_en_WB = wrw;
    v.in.mispredict_EX = misp;
    v.fa = fa; v.fb = fb; v.ctl = ctl;
    return v;
  endfunction

  task automatic setInputs(input in_t s);
    rs1_ID = s.rs1_ID; rs2_ID = s.rs2_ID; rd_EX = s.rd_EX;
    is_load_EX = s.is_load_EX; reg_wr_en_EX = s.reg_wr_en_EX;
    rs1_EX = s.rs1_EX; rs2_EX = s.rs2_EX;
    rd_MEM = s.rd_MEM; reg_wr_en_MEM = s.reg_wr_en_MEM;
    rd_WB = s.rd_WB; reg_wr_en_WB = s.reg_wr_en_WB;
    mispredict_EX = s.mispredict_EX; mem_req_MEM = s.mem_req_MEM; dmem_ready = s.dmem_ready;
  endtask

  task automatic applyStimulus(input in_t s);
    @(negedge clk);
    setInputs(s);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] e_ctl,
                             input logic [1:0] e_fa, input logic [1:0] e_fb);
    total++;
    if ({ctl_obs, fwd_a_sel, fwd_b_sel} !== {e_ctl, e_fa, e_fb}) begin
      bad++;
      $display("[TB] FAIL %s: got ctl=%b fa=%b fb=%b, want ctl=%b fa=%b fb=%b",
               name, ctl_obs, fwd_a_sel, fwd_b_sel, e_ctl, e_fa, e_fb);
    end
  endtask

  task automatic checkVal(input string name, input logic [XLEN-1:0] got,
                          input logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  // Reset is asserted with inputs that would otherwise forward and load-use stall.
  task automatic doReset();
    in_t s;
    s = '0;
    s.rs1_EX = 5; s.rs2_EX = 5; s.rd_MEM = 5; s.reg_wr_en_MEM = 1'b1;
    s.is_load_EX = 1'b1; s.reg_wr_en_EX = 1'b1; s.rd_EX = 4; s.rs1_ID = 4;
    s.mem_req_MEM = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    setInputs(s);
    #1;
    checkOutput("reset_hold", NONE, 2'b00, 2'b00);
    checkVal("reset_cnt", stall_cnt, '0);
    checkVal("reset_timeout", XLEN'(dmem_timeout), '0);
    @(negedge clk);
    reset = 1'b0;
    setInputs('0);
  endtask

  function automatic logic [1:0] refFwd(input logic [4:0] rs, rdm, input logic wrm,
                                        input logic [4:0] rdw, input logic wrw);
    if (rs == 0) return 2'b00;
    if (wrm && rdm == rs) return 2'b01;
    if (wrw && rdw == rs) return 2'b10;
    return 2'b00;
  endfunction

  vec_t vecs[$];
  in_t  s;

  initial begin
    bit      m_err, m_to, frz, lu;
    int      m_wait;
    longint  m_cnt;
    logic [6:0] e_ctl;

    setInputs('0);
    #12;
    doReset();

    // Combinational vectors, no memory access in flight.
    vecs.push_back(fv(0,0,0,0,0, 5,3, 5,1, 5,1, 0, 2'b01,2'b00, NONE));
    vecs.push_back(fv(0,0,0,0,0, 0,0, 0,1, 0,1, 0, 2'b00,2'b00, NONE));
    vecs.push_back(fv(0,0,0,0,0, 6,4, 4,1, 6,1, 0, 2'b10,2'b01, NONE));
    vecs.push_back(fv(0,0,0,0,0, 6,6, 6,0, 6,0, 0, 2'b00,2'b00, NONE));
    vecs.push_back(fv(0,0,0,0,0, 6,6, 6,0, 6,1, 0, 2'b10,2'b10, NONE));
    vecs.push_back(fv(1,7,7,1,1, 0,0, 0,0, 0,0, 0, 2'b00,2'b00, LU));
    vecs.push_back(fv(0,0,0,0,0, 0,0, 0,0, 0,0, 0, 2'b00,2'b00, NONE));
    vecs.push_back(fv(1,7,7,1,1, 0,0, 0,0, 0,0, 1, 2'b00,2'b00, MSP));
    vecs.push_back(fv(0,0,0,1,1, 0,0, 0,0, 0,0, 0, 2'b00,2'b00, NONE));
    vecs.push_back(fv(7,0,7,0,1, 0,0, 0,0, 0,0, 0, 2'b00,2'b00, NONE));
    vecs.push_back(fv(7,0,7,1,0, 0,0, 0,0, 0,0, 0, 2'b00,2'b00, NONE));
    vecs.push_back(fv(9,2,9,1,1, 0,0, 0,0, 0,0, 0, 2'b00,2'b00, LU));
    vecs.push_back(fv(0,0,0,0,0, 0,0, 0,0, 0,0, 1, 2'b00,2'b00, MSP));
    vecs.push_back(fv(3,3,3,1,1, 3,3, 3,1, 3,1, 0, 2'b01,2'b01, LU));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].in);
      checkOutput($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].fa, vecs[i].fb);
    end
    checkVal("vec_cnt", stall_cnt, '0);

    // Three wait cycles then ready.
    s = '0; s.mem_req_MEM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(s);
      checkOutput($sformatf("wait%0d", i), FRZ, 2'b00, 2'b00);
    end
    s.dmem_ready = 1'b1;
    applyStimulus(s);
    checkOutput("wait_ready", NONE, 2'b00, 2'b00);
    checkVal("wait_cnt3", stall_cnt, 3);

    // Zero-wait access back in RUN.
    applyStimulus(s);
    checkOutput("zero_wait", NONE, 2'b00, 2'b00);
    applyStimulus('0);
    checkOutput("zero_wait_after", NONE, 2'b00, 2'b00);
    checkVal("zero_wait_cnt", stall_cnt, 3);

    // Mispredict masked by freeze, re-presented on release.
    s = '0; s.mem_req_MEM = 1'b1; s.mispredict_EX = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(s);
      checkOutput($sformatf("frz_misp%0d", i), FRZ, 2'b00, 2'b00);
    end
    s.dmem_ready = 1'b1;
    applyStimulus(s);
    checkOutput("misp_release", MSP, 2'b00, 2'b00);
    checkVal("misp_cnt", stall_cnt, 5);
    applyStimulus('0);
    checkOutput("misp_done", NONE, 2'b00, 2'b00);

    // Timeout: flag rises after TIMEOUT+1 frozen cycles and is terminal.
    doReset();
    s = '0; s.mem_req_MEM = 1'b1;
    for (int i = 0; i < TIMEOUT + 1; i++) begin
      applyStimulus(s);
      checkOutput($sformatf("to_wait%0d", i), FRZ, 2'b00, 2'b00);
    end
    checkVal("to_not_yet", XLEN'(dmem_timeout), 0);
    applyStimulus(s);
    checkVal("to_flag", XLEN'(dmem_timeout), 1);
    checkVal("to_cnt", stall_cnt, TIMEOUT + 1);
    s.dmem_ready = 1'b1;
    applyStimulus(s);
    checkOutput("err_ignores_ready", FRZ, 2'b00, 2'b00);
    checkVal("err_cnt", stall_cnt, TIMEOUT + 2);
    #2 reset = 1'b1;
    #1;
    checkOutput("err_reset_now", NONE, 2'b00, 2'b00);
    checkVal("err_reset_flag", XLEN'(dmem_timeout), 0);
    checkVal("err_reset_cnt", stall_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus('0);
    checkOutput("after_err_run", NONE, 2'b00, 2'b00);
    s = '0; s.mem_req_MEM = 1'b1; s.dmem_ready = 1'b1;
    applyStimulus(s);
    checkOutput("after_err_passthru", NONE, 2'b00, 2'b00);

    // Randomized run against a cycle-level model of the wait/freeze rules.
    doReset();
    m_err = 0; m_to = 0; m_wait = 0; m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      s = '0;
      s.rs1_ID = 5'($urandom_range(0, 3)); s.rs2_ID = 5'($urandom_range(0, 3));
      s.rd_EX  = 5'($urandom_range(0, 3));
      s.rs1_EX = 5'($urandom_range(0, 3)); s.rs2_EX = 5'($urandom_range(0, 3));
      s.rd_MEM = 5'($urandom_range(0, 3)); s.rd_WB  = 5'($urandom_range(0, 3));
      s.is_load_EX    = ($urandom_range(0, 2) == 0);
      s.reg_wr_en_EX  = 1'($urandom);
      s.reg_wr_en_MEM = 1'($urandom);
      s.reg_wr_en_WB  = 1'($urandom);
      s.mispredict_EX = ($urandom_range(0, 4) == 0);
      s.mem_req_MEM   = 1'($urandom);
      s.dmem_ready    = 1'($urandom);
      applyStimulus(s);

      frz = m_err || ((m_wait > 0) ? !(s.mem_req_MEM && s.dmem_ready)
                                   : (s.mem_req_MEM && !s.dmem_ready));
      lu  = s.is_load_EX && s.reg_wr_en_EX && (s.rd_EX != 0) &&
            (s.rd_EX == s.rs1_ID || s.rd_EX == s.rs2_ID);
      e_ctl = frz ? FRZ : (s.mispredict_EX ? MSP : (lu ? LU : NONE));
      checkOutput($sformatf("rand%0d", n), e_ctl,
                  refFwd(s.rs1_EX, s.rd_MEM, s.reg_wr_en_MEM, s.rd_WB, s.reg_wr_en_WB),
                  refFwd(s.rs2_EX, s.rd_MEM, s.reg_wr_en_MEM, s.rd_WB, s.reg_wr_en_WB));
      checkVal($sformatf("rand_cnt%0d", n), stall_cnt, XLEN'(m_cnt));
      checkVal($sformatf("rand_to%0d", n), XLEN'(dmem_timeout), XLEN'(m_to));

      if (frz && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (!m_err) begin
        if (frz) begin
          m_wait++;
          if (m_wait > TIMEOUT) begin
            m_err = 1;
            m_to  = 1;
          end
        end else begin
          m_wait = 0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
